// File: rtl/pixel_fb_writer_if.sv
// rtl/pixel_fb_writer_if.sv - pixel stream in / framebuffer write port bundle for pixel_fb_writer
// Stats ports exist only when PIXEL_FB_WRITER_STATS_EN is defined.
interface pixel_fb_writer_if #(
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 720,
    parameter int COLOR_WIDTH = 24
);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    logic                   frame_start_in;
    logic                   pixel_valid_in;
    logic [19:0]            pixel_in;
    logic [COLOR_WIDTH-1:0] color_in;
    logic                   last_in;
    logic [AW-1:0]          fb_addr_out;
    logic [COLOR_WIDTH-1:0] fb_data_out;
    logic                   fb_we_out;
    logic                   busy_out;
    logic                   tri_done_out;
    logic                   overflow_out;
`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [31:0]            pixels_written_out;
    logic [15:0]            pixels_discarded_out;
`endif

    modport master (
        output frame_start_in, pixel_valid_in, pixel_in, color_in, last_in,
        input  fb_addr_out, fb_data_out, fb_we_out, busy_out, tri_done_out, overflow_out
`ifdef PIXEL_FB_WRITER_STATS_EN
        , input pixels_written_out, pixels_discarded_out
`endif
    );

    modport slave (
        input  frame_start_in, pixel_valid_in, pixel_in, color_in, last_in,
        output fb_addr_out, fb_data_out, fb_we_out, busy_out, tri_done_out, overflow_out
`ifdef PIXEL_FB_WRITER_STATS_EN
        , output pixels_written_out, pixels_discarded_out
`endif
    );
endinterface

// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - framebuffer clear + pixel write sink with FWFT pixel FIFO
// Optional write/discard counters enabled by PIXEL_FB_WRITER_STATS_EN.
module pixel_fb_writer #(
    parameter int                     WIDTH       = 1024,
    parameter int                     HEIGHT      = 720,
    parameter int                     COLOR_WIDTH = 24,
    parameter int                     FIFO_DEPTH  = 8,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR    = '0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    pixel_fb_writer_if.slave bus
);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 20 + COLOR_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [10:0]   X_LIM     = 11'(WIDTH);
    localparam logic [10:0]   Y_LIM     = 11'(HEIGHT);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACCEPT} state_t;

    state_t                 state;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic                   pending_last;
    logic [AW-1:0]          addr_q;
    logic [COLOR_WIDTH-1:0] data_q;
    logic                   we_q, busy_q, done_q, ovf_q;

    logic                   frame_start, pop, push, drop, in_bounds, wr_next;
    logic                   pending_next, done_next;
    logic [EW-1:0]          head;
    logic [9:0]             hx, hy;
    logic [COLOR_WIDTH-1:0] hc;
    logic [PW:0]            count_next;
    logic [AW-1:0]          lin_addr;
    state_t                 state_next;

    always_comb begin
        frame_start = bus.frame_start_in;
        head        = mem[rd_ptr];
        hx          = head[EW-1:EW-10];
        hy          = head[EW-11:COLOR_WIDTH];
        hc          = head[COLOR_WIDTH-1:0];
        in_bounds   = ({1'b0, hx} < X_LIM) && ({1'b0, hy} < Y_LIM);
        lin_addr    = AW'(hy) * AW'(WIDTH) + AW'(hx);
        pop         = (state == S_ACCEPT) && (count != '0) && !frame_start;
        // a full FIFO still takes a push when the head leaves the same cycle
        push        = bus.pixel_valid_in && !frame_start && ((count != FULL_CNT) || pop);
        drop        = bus.pixel_valid_in && !frame_start && (count == FULL_CNT) && !pop;
        wr_next     = pop && in_bounds;
        count_next  = count + (PW+1)'(push) - (PW+1)'(pop);
        pending_next = pending_last || bus.last_in;

        state_next = state;
        if (frame_start)
            state_next = S_CLEAR;
        else if ((state == S_CLEAR) && (addr_q == LAST_ADDR))
            state_next = S_ACCEPT;

        // predict next cycle's idle condition so the done pulse is a registered output
        done_next = (state_next == S_ACCEPT) && pending_next && (count_next == '0)
                    && !wr_next && !frame_start;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending_last <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.pixel_in, bus.color_in};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count  <= count_next;
            state  <= state_next;
            done_q <= done_next;

            if (frame_start) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                pending_last <= 1'b0;
                ovf_q        <= 1'b0;
                we_q         <= 1'b1;
                addr_q       <= '0;
                data_q       <= BG_COLOR;
                busy_q       <= 1'b1;
            end else begin
                if (drop)
                    ovf_q <= 1'b1;
                pending_last <= done_next ? 1'b0 : pending_next;
                case (state)
                    S_CLEAR: begin
                        data_q <= BG_COLOR;
                        if (addr_q == LAST_ADDR) begin
                            we_q   <= 1'b0;
                            busy_q <= 1'b0;
                        end else begin
                            we_q   <= 1'b1;
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                    S_ACCEPT: begin
                        we_q <= wr_next;
                        if (wr_next) begin
                            addr_q <= lin_addr;
                            data_q <= hc;
                        end
                    end
                    default: begin
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fb_addr_out  = addr_q;
    assign bus.fb_data_out  = data_q;
    assign bus.fb_we_out    = we_q;
    assign bus.busy_out     = busy_q;
    assign bus.tri_done_out = done_q;
    assign bus.overflow_out = ovf_q;

`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [31:0] written_q;
    logic [15:0] disc_q;
    logic [1:0]  disc_inc;
    logic [16:0] disc_sum;

    always_comb begin
        disc_inc = {1'b0, pop && !in_bounds} + {1'b0, drop};
        disc_sum = {1'b0, disc_q} + 17'(disc_inc);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            written_q <= '0;
            disc_q    <= '0;
        end else if (frame_start) begin
            written_q <= '0;
            disc_q    <= '0;
        end else begin
            if (wr_next && (written_q != '1))
                written_q <= written_q + 32'd1;
            disc_q <= disc_sum[16] ? '1 : disc_sum[15:0];
        end
    end

    assign bus.pixels_written_out   = written_q;
    assign bus.pixels_discarded_out = disc_q;
`endif
endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sink for the rasteriser pixel stream. Consumes `{x[19:10], y[9:0]}` pixel coordinates plus a 24-bit color, as produced by the triangle fill logic.
- Clears the framebuffer at frame start, then turns each in-bounds pixel into a framebuffer RAM write (address `y*WIDTH + x`).
- Buffers bursts in a small FIFO, because the upstream producer has no backpressure.
- Signals per-triangle completion once every buffered pixel has been written.

Parameters:
- WIDTH, 1024, screen width in pixels
- HEIGHT, 720, screen height in pixels
- COLOR_WIDTH, 24, framebuffer word width
- FIFO_DEPTH, 8, pixel buffer entries (power of two, >=2)
- BG_COLOR, 24'h000000, color written during clear

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- frame_start_in  input  1  single-cycle pulse: clear framebuffer, start new frame
- pixel_valid_in  input  1  single-cycle: pixel_in/color_in valid
- pixel_in  input  20  {x[19:10], y[9:0]}
- color_in  input  COLOR_WIDTH  color for pixel_in
- last_in  input  1  single-cycle: current triangle's pixel stream finished
- fb_addr_out  output  $clog2(WIDTH*HEIGHT)  framebuffer write address
- fb_data_out  output  COLOR_WIDTH  framebuffer write data
- fb_we_out  output  1  framebuffer write enable, one word per cycle
- busy_out  output  1  high while clearing
- tri_done_out  output  1  single-cycle pulse: triangle fully written
- overflow_out  output  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock (clk_in). Reset is asynchronous and active-low (rst_n_in); every flop clears on assertion, independent of clk_in.
- Reset values: all outputs 0, FIFO empty, pending_last=0, state=IDLE.
- State IDLE: pixels are still pushed into the FIFO but not written. frame_start_in moves to CLEAR.
- State CLEAR:
  - Clear counter starts at 0.
  - Each cycle: fb_we_out=1, fb_addr_out=counter, fb_data_out=BG_COLOR.
  - After address WIDTH*HEIGHT-1 the next state is ACCEPT. A clear takes exactly WIDTH*HEIGHT write cycles.
  - busy_out=1 throughout.
  - Pixels arriving during CLEAR are pushed into the FIFO, not written.
- State ACCEPT:
  - FIFO is first-word-fall-through. When it is non-empty, pop the head each cycle.
  - On pop, register address = y*WIDTH + x (full multiply, no shift shortcut) and data = color. fb_we_out is high the next cycle.
  - Popped entries with x>=WIDTH or y>=HEIGHT are discarded: no write, pop still consumed.
- Latency: pixel_valid_in in cycle k, ACCEPT state, FIFO empty -> fb_we_out=1 in cycle k+2. Sustained throughput is 1 pixel/cycle.
- FIFO:
  - Push on pixel_valid_in. Push and pop in the same cycle are legal, including when full: the entry is accepted.
  - Push when full with no pop: pixel dropped, overflow_out set.
  - overflow_out is cleared only by frame_start_in or reset.
  - Pointers wrap modulo FIFO_DEPTH. A count of FIFO_DEPTH+1 bits distinguishes full from empty.
- last_in:
  - Sets pending_last.
  - tri_done_out pulses for exactly one cycle in the first ACCEPT cycle in which pending_last=1, the FIFO is empty, and no write is in flight (fb_we_out=0 this cycle and nothing popped this cycle). pending_last clears on that pulse.
  - last_in coincident with pixel_valid_in: the pixel is counted before done, i.e. done waits for it.
  - last_in while pending_last=1: merged, one pulse.
- frame_start_in in any state (including mid-CLEAR or mid-ACCEPT):
  - Flush FIFO, cancel any in-flight write, clear pending_last and overflow_out.
  - Restart CLEAR at address 0 the next cycle.
  - A pixel_valid_in in the same cycle is dropped.
- fb_we_out is never high for two writes to the same cycle. No writes to addresses >= WIDTH*HEIGHT, ever.

Optional Feature:
- Macro: PIXEL_FB_WRITER_STATS_EN.
- Defined:
  - Adds output pixels_written_out (32 bits): count of ACCEPT-state framebuffer writes since the last frame_start_in. Clear writes are not counted.
  - Adds output pixels_discarded_out (16 bits): out-of-bounds pops plus FIFO drops.
  - Both counters zero on reset and frame_start_in, and saturate at all-ones.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. WIDTH=4, HEIGHT=3; reset, then frame_start_in -> busy_out=1 for 12 cycles, fb_addr_out 0..11 with fb_data_out=BG_COLOR, then busy_out=0.
2. ACCEPT, FIFO empty; pixel_in={x=2,y=1}, color=24'hFF0000 in cycle k -> cycle k+2: fb_we_out=1, fb_addr_out=6, fb_data_out=24'hFF0000.
3. 5 consecutive pixels, then last_in one cycle later -> 5 writes on consecutive cycles; tri_done_out single pulse the cycle after the last write.
4. FIFO_DEPTH=8; 10 pixels pushed during CLEAR -> 8 written after clear, overflow_out=1; the next frame_start_in clears overflow_out.
5. Pixel {x=4,y=0} (x>=WIDTH) followed by {x=0,y=2} -> only address 8 written; with PIXEL_FB_WRITER_STATS_EN, pixels_discarded_out=1 and pixels_written_out=1.
6. frame_start_in mid-ACCEPT with 3 pixels buffered, then rst_n_in low asynchronously mid-CLEAR -> no buffered pixel written, clear restarts at 0; on reset, all outputs 0 immediately without a clock edge.
